// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage: IF/ID register, decode, RAW scoreboard stall, branch wait
module id_stage #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [PC_W-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            br_resolve,
  output logic            stall_if,
  output logic            id_valid,
  output logic [PC_W-1:0] id_pc,
  output logic [6:0]      id_opcode,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7,
  output logic [31:0]     id_imm,
  output logic            id_reg_write,
  output logic            illegal_instr
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] BR_WAIT = 1'b1;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;

  logic [0:0]      state;
  logic            ifid_valid;
  logic [PC_W-1:0] ifid_pc;
  logic [31:0]     ifid_instr;
  logic            sb0_valid, sb1_valid;
  logic [4:0]      sb0_rd, sb1_rd;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic        is_r, is_i, is_lw, is_sw, is_b, is_j;
  logic        legal, is_zero, uses_rs1, uses_rs2, reg_write;
  logic [31:0] imm;
  logic        hit1, hit2, hazard, in_run, issue, issue_br, drop_illegal;

  always_comb begin
    opcode   = ifid_instr[6:0];
    rd       = ifid_instr[11:7];
    rs1      = ifid_instr[19:15];
    rs2      = ifid_instr[24:20];
    is_r     = (opcode == OP_R);
    is_i     = (opcode == OP_I);
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_b     = (opcode == OP_B);
    is_j     = (opcode == OP_J);
    legal    = is_r | is_i | is_lw | is_sw | is_b | is_j;
    is_zero  = (ifid_instr == 32'h0);
    uses_rs1 = is_r | is_i | is_lw | is_sw | is_b;
    uses_rs2 = is_r | is_sw | is_b;
    reg_write = (is_r | is_i | is_lw | is_j) && (rd != 5'd0);
    imm = 32'h0;
    if (is_i || is_lw)
      imm = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
    else if (is_sw)
      imm = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
    else if (is_b)
      imm = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
             ifid_instr[30:25], ifid_instr[11:8], 1'b0};
    else if (is_j)
      imm = {{11{ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12],
             ifid_instr[20], ifid_instr[30:21], 1'b0};
  end

  // No forwarding: any source matching an older in-flight writer must wait for WB.
  always_comb begin
    hit1 = uses_rs1 && (rs1 != 5'd0) &&
           ((sb0_valid && sb0_rd == rs1) || (sb1_valid && sb1_rd == rs1));
    hit2 = uses_rs2 && (rs2 != 5'd0) &&
           ((sb0_valid && sb0_rd == rs2) || (sb1_valid && sb1_rd == rs2));
    hazard       = ifid_valid && (hit1 || hit2);
    in_run       = (state == RUN);
    issue        = in_run && ifid_valid && !hazard && legal;
    issue_br     = issue && (is_b || is_j);
    drop_illegal = in_run && ifid_valid && !hazard && !legal && !is_zero;
    stall_if     = in_run ? (hazard || issue_br) : !br_resolve;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else if (in_run && issue_br) begin
      state <= BR_WAIT;
    end else if (!in_run && br_resolve) begin
      state <= RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= 32'h0;
    end else if (issue_br) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= 32'h0;
    end else if (!stall_if) begin
      ifid_valid <= if_valid;
      ifid_pc    <= if_pc;
      ifid_instr <= if_instr;
    end
  end

  // WB is write-before-read in the register file, so only EX and MEM are tracked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb0_valid <= 1'b0;
      sb0_rd    <= 5'd0;
      sb1_valid <= 1'b0;
      sb1_rd    <= 5'd0;
    end else begin
      sb1_valid <= sb0_valid;
      sb1_rd    <= sb0_rd;
      sb0_valid <= issue && reg_write;
      sb0_rd    <= (issue && reg_write) ? rd : 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid      <= 1'b0;
      id_pc         <= '0;
      id_opcode     <= 7'd0;
      id_rd         <= 5'd0;
      id_rs1        <= 5'd0;
      id_rs2        <= 5'd0;
      id_funct3     <= 3'd0;
      id_funct7     <= 7'd0;
      id_imm        <= 32'h0;
      id_reg_write  <= 1'b0;
      illegal_instr <= 1'b0;
    end else begin
      illegal_instr <= drop_illegal;
      if (issue) begin
        id_valid     <= 1'b1;
        id_pc        <= ifid_pc;
        id_opcode    <= opcode;
        id_rd        <= rd;
        id_rs1       <= rs1;
        id_rs2       <= rs2;
        id_funct3    <= ifid_instr[14:12];
        id_funct7    <= ifid_instr[31:25];
        id_imm       <= imm;
        id_reg_write <= reg_write;
      end else begin
        id_valid     <= 1'b0;
        id_pc        <= '0;
        id_opcode    <= 7'd0;
        id_rd        <= 5'd0;
        id_rs1       <= 5'd0;
        id_rs2       <= 5'd0;
        id_funct3    <= 3'd0;
        id_funct7    <= 7'd0;
        id_imm       <= 32'h0;
        id_reg_write <= 1'b0;
      end
    end
  end

endmodule
